// File: rtl/render_target_mem.sv
// render_target_mem: colour + depth render target behind the rasterizer.
// Holds the frame buffer and Z buffer, serves the rasterizer's Z read and
// pixel/Z write ports, clears both arrays between frames and streams the
// finished frame out through a valid/ready dump port.
// Build option: define RENDER_TARGET_FLIP_Y_EN to dump rows from V_RES-1
// down to 0 (top-down image from a bottom-up buffer). Clear and write
// behaviour do not depend on it.
//
// Dump handshake: a beat transfers on a rising edge where o_dump_valid and
// i_dump_ready are both high; while o_dump_valid is high and i_dump_ready is
// low, o_dump_pixel/x/y/last stay stable; o_dump_valid never drops without a
// transfer except on reset.
module render_target_mem #(
    parameter int               H_RES     = 320,
    parameter int               V_RES     = 240,
    parameter int               PIX_W     = 12,
    parameter int               Z_W       = 8,
    parameter int               ADDR_W    = 17,
    parameter logic [PIX_W-1:0] PIX_CLEAR = '0,
    parameter logic [Z_W-1:0]   Z_CLEAR   = '1,
    localparam int              X_W       = $clog2(H_RES),
    localparam int              Y_W       = $clog2(V_RES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear_start,
    input  logic [ADDR_W-1:0] i_zb_r_addr,
    output logic [Z_W-1:0]    o_zb_r_data,
    input  logic              i_fb_we,
    input  logic [ADDR_W-1:0] i_fb_addr,
    input  logic [PIX_W-1:0]  i_fb_pixel,
    input  logic              i_zb_we,
    input  logic [ADDR_W-1:0] i_zb_w_addr,
    input  logic [Z_W-1:0]    i_zb_w_data,
    input  logic              i_dump_start,
    output logic              o_dump_valid,
    input  logic              i_dump_ready,
    output logic [PIX_W-1:0]  o_dump_pixel,
    output logic [X_W-1:0]    o_dump_x,
    output logic [Y_W-1:0]    o_dump_y,
    output logic              o_dump_last,
    output logic              o_busy,
    output logic [1:0]        dbg_state
);

    localparam int                NPIX   = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] NPIX_A = ADDR_W'(NPIX);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NPIX - 1);
    localparam logic [X_W-1:0]    LAST_X = X_W'(H_RES - 1);
`ifdef RENDER_TARGET_FLIP_Y_EN
    localparam logic [Y_W-1:0]    FIRST_Y  = Y_W'(V_RES - 1);
    localparam logic [Y_W-1:0]    LAST_Y   = '0;
    localparam logic [ADDR_W-1:0] FIRST_A  = ADDR_W'((V_RES - 1) * H_RES);
    // from the last pixel of row y to the first pixel of row y-1
    localparam logic [ADDR_W-1:0] ROW_BACK = ADDR_W'(2 * H_RES - 1);
`else
    localparam logic [Y_W-1:0]    FIRST_Y  = '0;
    localparam logic [Y_W-1:0]    LAST_Y   = Y_W'(V_RES - 1);
    localparam logic [ADDR_W-1:0] FIRST_A  = '0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DUMP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [PIX_W-1:0] fb_mem [NPIX];
    logic [Z_W-1:0]   zb_mem [NPIX];

    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we, issue, pop, dump_begin;
    logic              fb_ok, zb_ok;
    logic [1:0]        occ;

    // fetch pointer and the one-cycle memory read stage
    logic [ADDR_W-1:0] fetch_addr;
    logic [X_W-1:0]    fetch_x;
    logic [Y_W-1:0]    fetch_y;
    logic              fetch_done, fetch_last;
    logic              m_valid, m_last;
    logic [X_W-1:0]    m_x;
    logic [Y_W-1:0]    m_y;
    logic [PIX_W-1:0]  m_pixel;

    // skid entry behind the output register
    logic              skid_valid, skid_last;
    logic [X_W-1:0]    skid_x;
    logic [Y_W-1:0]    skid_y;
    logic [PIX_W-1:0]  skid_pixel;

    assign pop        = o_dump_valid && i_dump_ready;
    assign fetch_last = (fetch_x == LAST_X) && (fetch_y == LAST_Y);
    assign fb_ok      = i_fb_we && (i_fb_addr < NPIX_A) && (state_q != ST_CLEAR);
    assign zb_ok      = i_zb_we && (i_zb_w_addr < NPIX_A) && (state_q != ST_CLEAR);
    assign occ        = {1'b0, o_dump_valid} + {1'b0, skid_valid} + {1'b0, m_valid};
    assign o_busy     = (state_q != ST_IDLE);
    assign dbg_state  = state_q;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // next state, clear strobe and fetch issue; a read is issued only when
    // the output register, skid entry and read stage can still absorb it
    always_comb begin
        state_d    = state_q;
        clr_we     = 1'b0;
        issue      = 1'b0;
        dump_begin = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_clear_start) begin
                    state_d = ST_CLEAR;
                end else if (i_dump_start) begin
                    state_d    = ST_DUMP;
                    dump_begin = 1'b1;
                end
            end
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_addr == LAST_A) state_d = ST_IDLE;
            end
            ST_DUMP: begin
                issue = !fetch_done && ((occ < 2'd2) || ((occ == 2'd2) && pop));
                if (pop && o_dump_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // clear address counter, restarts from 0 every time CLEAR is entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    clr_addr <= '0;
        else if (state_q != ST_CLEAR) clr_addr <= '0;
        else                        clr_addr <= clr_addr + ADDR_W'(1);
    end

    // frame buffer: one write port (clear has priority) and the dump read port
    always_ff @(posedge clk) begin
        if (clr_we)     fb_mem[clr_addr]  <= PIX_CLEAR;
        else if (fb_ok) fb_mem[i_fb_addr] <= i_fb_pixel;
        if (issue)      m_pixel <= fb_mem[fetch_addr];
    end

    // Z buffer write port (clear has priority)
    always_ff @(posedge clk) begin
        if (clr_we)     zb_mem[clr_addr]    <= Z_CLEAR;
        else if (zb_ok) zb_mem[i_zb_w_addr] <= i_zb_w_data;
    end

    // Z read port, read-first; clear in progress or out-of-range reads far plane
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                             o_zb_r_data <= '0;
        else if ((state_q == ST_CLEAR) || (i_zb_r_addr >= NPIX_A)) o_zb_r_data <= Z_CLEAR;
        else                                                 o_zb_r_data <= zb_mem[i_zb_r_addr];
    end

    // fetch pointer walks the frame in dump order and feeds the read stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_addr <= '0;
            fetch_x    <= '0;
            fetch_y    <= '0;
            fetch_done <= 1'b0;
            m_valid    <= 1'b0;
            m_x        <= '0;
            m_y        <= '0;
            m_last     <= 1'b0;
        end else if (dump_begin) begin
            fetch_addr <= FIRST_A;
            fetch_x    <= '0;
            fetch_y    <= FIRST_Y;
            fetch_done <= 1'b0;
            m_valid    <= 1'b0;
        end else begin
            m_valid <= issue;
            if (issue) begin
                m_x    <= fetch_x;
                m_y    <= fetch_y;
                m_last <= fetch_last;
                if (fetch_last) begin
                    fetch_done <= 1'b1;
                end else if (fetch_x == LAST_X) begin
                    fetch_x <= '0;
`ifdef RENDER_TARGET_FLIP_Y_EN
                    fetch_y    <= fetch_y - Y_W'(1);
                    fetch_addr <= fetch_addr - ROW_BACK;
`else
                    fetch_y    <= fetch_y + Y_W'(1);
                    fetch_addr <= fetch_addr + ADDR_W'(1);
`endif
                end else begin
                    fetch_x    <= fetch_x + X_W'(1);
                    fetch_addr <= fetch_addr + ADDR_W'(1);
                end
            end
        end
    end

    // output register plus skid entry: keeps the beat stable under stall and
    // lets a new beat follow every cycle while ready stays high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_dump_valid <= 1'b0;
            o_dump_pixel <= '0;
            o_dump_x     <= '0;
            o_dump_y     <= '0;
            o_dump_last  <= 1'b0;
            skid_valid   <= 1'b0;
            skid_pixel   <= '0;
            skid_x       <= '0;
            skid_y       <= '0;
            skid_last    <= 1'b0;
        end else if (state_q != ST_DUMP) begin
            o_dump_valid <= 1'b0;
            skid_valid   <= 1'b0;
        end else if (pop && skid_valid) begin
            o_dump_valid <= 1'b1;
            o_dump_pixel <= skid_pixel;
            o_dump_x     <= skid_x;
            o_dump_y     <= skid_y;
            o_dump_last  <= skid_last;
            skid_valid   <= m_valid;
            skid_pixel   <= m_pixel;
            skid_x       <= m_x;
            skid_y       <= m_y;
            skid_last    <= m_last;
        end else if (pop || !o_dump_valid) begin
            o_dump_valid <= m_valid;
            o_dump_pixel <= m_pixel;
            o_dump_x     <= m_x;
            o_dump_y     <= m_y;
            o_dump_last  <= m_last;
        end else if (m_valid) begin
            skid_valid <= 1'b1;
            skid_pixel <= m_pixel;
            skid_x     <= m_x;
            skid_y     <= m_y;
            skid_last  <= m_last;
        end
    end

endmodule
